sync_bus_qualify: RTL and testbench

//  Consumer stage placed directly after the two-flop CDC synchroniser.
//  - Takes the synchroniser's level bus, already in the clk domain.
//  - Accepts a new bus value only after it has held stable for STABLE_CNT cycles,

---
 rtl/sync_pkg.sv | 9 +
 rtl/sync_bus_qualify_if.sv | 28 ++
 rtl/sync_stable_cnt.sv | 50 +++++
 rtl/sync_bus_qualify.sv | 88 ++++++++
 tb/tb_sync_bus_qualify.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/sync_pkg.sv
// Shared defaults and bus type for the synchronised-bus qualifier.
package sync_pkg;

  localparam int unsigned SYNC_REG_WDTH_DEF = 1;
  localparam int unsigned STABLE_CNT_DEF    = 4;

  typedef logic [SYNC_REG_WDTH_DEF-1:0] sync_bus_t;

endpackage

// File: rtl/sync_bus_qualify_if.sv
// Bus/event bundle between the qualifier (slave) and its driver/consumer (master).
interface sync_bus_qualify_if
  import sync_pkg::*;
#(
  parameter int unsigned SYNC_REG_WDTH = SYNC_REG_WDTH_DEF
);

  logic [SYNC_REG_WDTH-1:0] sync_in;
  logic [SYNC_REG_WDTH-1:0] qual_val;
  logic [SYNC_REG_WDTH-1:0] rise;
  logic [SYNC_REG_WDTH-1:0] fall;
  logic                     chg_valid;
  logic [SYNC_REG_WDTH-1:0] chg_data;
  logic                     chg_ready;
  logic                     overrun;
  logic                     ovr_clr;

  modport master (
    output sync_in, chg_ready, ovr_clr,
    input  qual_val, rise, fall, chg_valid, chg_data, overrun
  );

  modport slave (
    input  sync_in, chg_ready, ovr_clr,
    output qual_val, rise, fall, chg_valid, chg_data, overrun
  );

endinterface

// File: rtl/sync_stable_cnt.sv
// Candidate register and stability counter; strobes qualify when a new value has
// held for STABLE_CNT consecutive samples.
module sync_stable_cnt
  import sync_pkg::*;
#(
  parameter int unsigned              SYNC_REG_WDTH = SYNC_REG_WDTH_DEF,
  parameter int unsigned              STABLE_CNT    = STABLE_CNT_DEF,
  parameter logic [SYNC_REG_WDTH-1:0] RST_VAL       = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SYNC_REG_WDTH-1:0] sync_in,
  input  logic [SYNC_REG_WDTH-1:0] qual_val,
  output logic [SYNC_REG_WDTH-1:0] cand,
  output logic                     qualify
);

  localparam int unsigned CNT_WDTH = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_WDTH-1:0] CntSat  = CNT_WDTH'(STABLE_CNT);
  localparam logic [CNT_WDTH-1:0] CntLast = CNT_WDTH'(STABLE_CNT - 1);

  logic [SYNC_REG_WDTH-1:0] cand_d, cand_q;
  logic [CNT_WDTH-1:0]      cnt_d, cnt_q;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync_in != cand_q) begin
      cand_d = sync_in;
      cnt_d  = '0;
    end else if (cnt_q != CntSat) begin
      cnt_d = cnt_q + CNT_WDTH'(1);
    end
  end

  // Reset saturates the counter so the reset value is never re-announced.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_q <= RST_VAL;
      cnt_q  <= CntSat;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cand    = cand_q;
  assign qualify = (sync_in == cand_q) && (cnt_q == CntLast) && (cand_q != qual_val);

endmodule

// File: rtl/sync_bus_qualify.sv
// Debounces a synchronised level bus, emits per-bit edge pulses and posts each
// qualified change on a valid/ready event port with sticky overrun.
module sync_bus_qualify
  import sync_pkg::*;
#(
  parameter int unsigned              SYNC_REG_WDTH = SYNC_REG_WDTH_DEF,
  parameter int unsigned              STABLE_CNT    = STABLE_CNT_DEF,
  parameter logic [SYNC_REG_WDTH-1:0] RST_VAL       = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  sync_bus_qualify_if.slave   bus
);

  logic [SYNC_REG_WDTH-1:0] cand;
  logic                     qualify;

  logic [SYNC_REG_WDTH-1:0] qual_d, qual_q;
  logic [SYNC_REG_WDTH-1:0] rise_d, rise_q;
  logic [SYNC_REG_WDTH-1:0] fall_d, fall_q;
  logic                     valid_d, valid_q;
  logic [SYNC_REG_WDTH-1:0] data_d, data_q;
  logic                     ovr_d, ovr_q;

  sync_stable_cnt #(
    .SYNC_REG_WDTH (SYNC_REG_WDTH),
    .STABLE_CNT    (STABLE_CNT),
    .RST_VAL       (RST_VAL)
  ) u_stable_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_in  (bus.sync_in),
    .qual_val (qual_q),
    .cand     (cand),
    .qualify  (qualify)
  );

  always_comb begin
    qual_d  = qual_q;
    rise_d  = '0;
    fall_d  = '0;
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    if (bus.ovr_clr) begin
      ovr_d = 1'b0;
    end
    if (qualify) begin
      qual_d  = cand;
      rise_d  = cand & ~qual_q;
      fall_d  = ~cand & qual_q;
      valid_d = 1'b1;
      data_d  = cand;
      // Overwriting an unaccepted event loses it; set wins over ovr_clr.
      if (valid_q && !bus.chg_ready) begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && bus.chg_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qual_q  <= RST_VAL;
      rise_q  <= '0;
      fall_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      qual_q  <= qual_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.qual_val  = qual_q;
  assign bus.rise      = rise_q;
  assign bus.fall      = fall_q;
  assign bus.chg_valid = valid_q;
  assign bus.chg_data  = data_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_sync_bus_qualify.sv
// Directed scoreboard bench: stimulus queues expected pulses/events, a negedge
// monitor pops and compares them as the DUT presents them.
module tb_sync_bus_qualify;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sync_bus_qualify_if #(.SYNC_REG_WDTH(4)) bus ();

  sync_bus_qualify #(
    .SYNC_REG_WDTH (4),
    .STABLE_CNT    (4),
    .RST_VAL       (4'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] pulse_q[$];  // {rise, fall}
  logic [3:0] evt_q[$];    // chg_data at acceptance

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse and every accepted event must match the next queued entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.rise != 4'h0 || bus.fall != 4'h0) begin
        if (pulse_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: got rise %h fall %h expected none at %0t",
                   bus.rise, bus.fall, $time);
        end else begin
          check("pulse", {bus.rise, bus.fall}, pulse_q.pop_front());
        end
      end
      if (bus.chg_valid && bus.chg_ready) begin
        if (evt_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: got %h expected none at %0t", bus.chg_data, $time);
        end else begin
          check("event", {4'h0, bus.chg_data}, {4'h0, evt_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.sync_in   = 4'h0;
    bus.chg_ready = 1'b0;
    bus.ovr_clr   = 1'b0;
    tick(3);
    check("rst_qual",    {4'h0, bus.qual_val}, 8'h00);
    check("rst_edges",   {bus.rise, bus.fall}, 8'h00);
    check("rst_valid",   {7'h0, bus.chg_valid}, 8'h00);
    check("rst_data",    {4'h0, bus.chg_data}, 8'h00);
    check("rst_overrun", {7'h0, bus.overrun}, 8'h00);
    rst_n = 1'b1;

    // 1: idle at reset value
    tick(20);
    check("t1_qual",  {4'h0, bus.qual_val}, 8'h00);
    check("t1_valid", {7'h0, bus.chg_valid}, 8'h00);

    // 2: 0 -> A, qualifies exactly STABLE_CNT edges after first sample
    bus.sync_in = 4'hA;
    pulse_q.push_back({4'hA, 4'h0});
    evt_q.push_back(4'hA);
    tick(4);
    check("t2_qual_early", {4'h0, bus.qual_val}, 8'h00);
    tick();
    check("t2_qual",  {4'h0, bus.qual_val}, 8'h0A);
    check("t2_valid", {7'h0, bus.chg_valid}, 8'h01);
    tick(3);
    check("t2_hold_data",  {4'h0, bus.chg_data}, 8'h0A);
    check("t2_hold_valid", {7'h0, bus.chg_valid}, 8'h01);
    bus.chg_ready = 1'b1;
    tick();
    bus.chg_ready = 1'b0;
    check("t2_accepted", {7'h0, bus.chg_valid}, 8'h00);

    // 3: short glitch to 5 then back to A
    bus.sync_in = 4'h5;
    tick(3);
    bus.sync_in = 4'hA;
    tick(10);
    check("t3_qual",  {4'h0, bus.qual_val}, 8'h0A);
    check("t3_valid", {7'h0, bus.chg_valid}, 8'h00);

    // 4: qualify 3 unaccepted, then C overwrites -> overrun
    bus.sync_in = 4'h3;
    pulse_q.push_back({4'h1, 4'h8});
    tick(5);
    check("t4_data3",   {4'h0, bus.chg_data}, 8'h03);
    check("t4_ovr0",    {7'h0, bus.overrun}, 8'h00);
    bus.sync_in = 4'hC;
    pulse_q.push_back({4'hC, 4'h3});
    evt_q.push_back(4'hC);
    tick(5);
    check("t4_dataC",   {4'h0, bus.chg_data}, 8'h0C);
    check("t4_ovr1",    {7'h0, bus.overrun}, 8'h01);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    check("t4_ovr_clr", {7'h0, bus.overrun}, 8'h00);
    bus.chg_ready = 1'b1;
    tick();
    bus.chg_ready = 1'b0;

    // 5: qualify 9 on the same edge that accepts 6
    bus.sync_in = 4'h6;
    pulse_q.push_back({4'h2, 4'h8});
    evt_q.push_back(4'h6);
    tick(5);
    bus.sync_in = 4'h9;
    pulse_q.push_back({4'h9, 4'h6});
    evt_q.push_back(4'h9);
    tick(4);
    bus.chg_ready = 1'b1;
    tick();
    bus.chg_ready = 1'b0;
    check("t5_valid", {7'h0, bus.chg_valid}, 8'h01);
    check("t5_data",  {4'h0, bus.chg_data}, 8'h09);
    check("t5_ovr",   {7'h0, bus.overrun}, 8'h00);
    bus.chg_ready = 1'b1;
    tick();
    bus.chg_ready = 1'b0;
    check("t5_drained", {7'h0, bus.chg_valid}, 8'h00);

    // 6: reset while a change to 0 is at cnt=2
    bus.sync_in = 4'h0;
    tick(3);
    rst_n = 1'b0;
    tick();
    check("t6_qual",    {4'h0, bus.qual_val}, 8'h00);
    check("t6_edges",   {bus.rise, bus.fall}, 8'h00);
    check("t6_valid",   {7'h0, bus.chg_valid}, 8'h00);
    check("t6_data",    {4'h0, bus.chg_data}, 8'h00);
    check("t6_overrun", {7'h0, bus.overrun}, 8'h00);
    rst_n = 1'b1;
    tick(10);
    check("t6_no_event", {7'h0, bus.chg_valid}, 8'h00);
    check("t6_qual_after", {4'h0, bus.qual_val}, 8'h00);

    check("pulse_q_empty", 8'(pulse_q.size()), 8'h00);
    check("evt_q_empty",   8'(evt_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
